// File: rtl/time_adder_seq.sv
// Digit-serial BCD HH:MM:SS time adder: one digit per clock, seconds first, with a programmable hour ceiling.
// Defining TIME_ADDER_SUB_EN adds a 'sub' input that selects A - B with borrow propagation.
module time_adder_seq #(
  parameter int HOUR_MAX = 99,
  parameter bit SATURATE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
`ifdef TIME_ADDER_SUB_EN
  input  logic       sub,
`endif
  input  logic [3:0] oHour10,
  input  logic [3:0] oHour1,
  input  logic [3:0] oMinute10,
  input  logic [3:0] oMinute1,
  input  logic [3:0] oSecond10,
  input  logic [3:0] oSecond1,
  input  logic [3:0] pHour10,
  input  logic [3:0] pHour1,
  input  logic [3:0] pMinute10,
  input  logic [3:0] pMinute1,
  input  logic [3:0] pSecond10,
  input  logic [3:0] pSecond1,
  output logic [3:0] Hour10,
  output logic [3:0] Hour1,
  output logic [3:0] Minute10,
  output logic [3:0] Minute1,
  output logic [3:0] Second10,
  output logic [3:0] Second1,
  output logic       busy,
  output logic       complete,
  output logic       recursive,
  output logic       overflow,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, SEC1, SEC10, MIN1, MIN10, HR, DONE} state_t;

  state_t          state_q;
  logic [5:0][3:0] a_q, b_q, res_q;
  logic            carry_q;
`ifdef TIME_ADDER_SUB_EN
  logic            sub_q;
  logic [5:0]      diff_d;
  logic [7:0]      hdiff_d;
`endif

  // Digit index 5 is the hour tens digit, index 0 the second units digit.
  logic [5:0][3:0] a_in, b_in;
  assign a_in = {oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1};
  assign b_in = {pHour10, pHour1, pMinute10, pMinute1, pSecond10, pSecond1};
  assign {Hour10, Hour1, Minute10, Minute1, Second10, Second1} = res_q;

  function automatic logic operand_bad(input logic [5:0][3:0] d);
    logic [7:0] hrs;
    hrs = 8'(d[5]) * 8'd10 + 8'(d[4]);
    return (d[4] > 4'd9) || (d[2] > 4'd9) || (d[0] > 4'd9) ||
           (d[3] > 4'd5) || (d[1] > 4'd5) || (hrs > 8'(HOUR_MAX));
  endfunction

  logic [1:0]      step_idx;
  logic [4:0]      lim_d;
  logic [4:0]      sum_d;
  logic [3:0]      dig_d;
  logic            cout_d;
  logic [7:0]      ha_d, hb_d, hsum_d, hour_d;
  logic            hovf_d;
  logic [3:0][3:0] fill_d;
  logic [3:0]      hour_tens_d, hour_units_d;

  always_comb begin
    case (state_q)
      SEC10:   step_idx = 2'd1;
      MIN1:    step_idx = 2'd2;
      MIN10:   step_idx = 2'd3;
      default: step_idx = 2'd0;
    endcase
    lim_d  = step_idx[0] ? 5'd6 : 5'd10;
    sum_d  = {1'b0, a_q[step_idx]} + {1'b0, b_q[step_idx]} + {4'd0, carry_q};
    cout_d = (sum_d >= lim_d);
    dig_d  = cout_d ? 4'(sum_d - lim_d) : sum_d[3:0];
    ha_d   = 8'(a_q[5]) * 8'd10 + 8'(a_q[4]);
    hb_d   = 8'(b_q[5]) * 8'd10 + 8'(b_q[4]);
    hsum_d = ha_d + hb_d + {7'd0, carry_q};
    hovf_d = (hsum_d > 8'(HOUR_MAX));
    // Minutes:seconds forced in place when an overflow saturates.
    fill_d = {4'd5, 4'd9, 4'd5, 4'd9};
    if (!hovf_d)       hour_d = hsum_d;
    else if (SATURATE) hour_d = 8'(HOUR_MAX);
    else               hour_d = hsum_d - 8'(HOUR_MAX + 1);
`ifdef TIME_ADDER_SUB_EN
    diff_d  = {2'b00, a_q[step_idx]} - {2'b00, b_q[step_idx]} - {5'd0, carry_q};
    hdiff_d = ha_d - hb_d - {7'd0, carry_q};
    if (sub_q) begin
      cout_d = diff_d[5];
      dig_d  = cout_d ? 4'(diff_d + {1'b0, lim_d}) : diff_d[3:0];
      hovf_d = (ha_d < (hb_d + {7'd0, carry_q}));
      fill_d = '0;
      if (!hovf_d)       hour_d = hdiff_d;
      else if (SATURATE) hour_d = 8'd0;
      else               hour_d = hdiff_d + 8'(HOUR_MAX + 1);
    end
`endif
    hour_tens_d  = 4'(hour_d / 8'd10);
    hour_units_d = 4'(hour_d % 8'd10);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      complete  <= 1'b0;
      recursive <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
`ifdef TIME_ADDER_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      complete <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            a_q       <= a_in;
            b_q       <= b_in;
            carry_q   <= 1'b0;
            err       <= operand_bad(a_in) | operand_bad(b_in);
            recursive <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
`ifdef TIME_ADDER_SUB_EN
            sub_q     <= sub;
`endif
            state_q   <= SEC1;
          end
        end
        SEC1, SEC10, MIN1, MIN10: begin
          res_q[step_idx] <= err ? 4'd0 : dig_d;
          carry_q         <= cout_d;
          if (!err && cout_d) recursive <= 1'b1;
          case (state_q)
            SEC1:    state_q <= SEC10;
            SEC10:   state_q <= MIN1;
            MIN1:    state_q <= MIN10;
            default: state_q <= HR;
          endcase
        end
        HR: begin
          if (err) begin
            res_q[5:4] <= '0;
          end else begin
            res_q[5] <= hour_tens_d;
            res_q[4] <= hour_units_d;
            if (hovf_d) begin
              overflow  <= 1'b1;
              recursive <= 1'b1;
              if (SATURATE) res_q[3:0] <= fill_d;
            end
          end
          complete <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_time_adder_seq.sv
// Bench for time_adder_seq: three instances (99/saturate, 23/wrap, 23/saturate) share stimulus;
// expected results are queued at stimulus time and compared when each operation completes.
`timescale 1ns/1ps
module tb_time_adder_seq;
  localparam int N = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;
`ifdef TIME_ADDER_SUB_EN
  logic sub   = 1'b0;
`endif
  logic [3:0] in_d [12];
  logic [3:0] r_d [N][6];
  logic busy_o [N];
  logic complete_o [N];
  logic rec_o [N];
  logic ovf_o [N];
  logic err_o [N];

  logic [26:0] sb_q [$];
  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    time_adder_seq #(.HOUR_MAX(gi == 0 ? 99 : 23), .SATURATE(gi != 1)) u_dut (
      .clock(clock), .reset(reset), .en(en),
`ifdef TIME_ADDER_SUB_EN
      .sub(sub),
`endif
      .oHour10(in_d[0]), .oHour1(in_d[1]), .oMinute10(in_d[2]),
      .oMinute1(in_d[3]), .oSecond10(in_d[4]), .oSecond1(in_d[5]),
      .pHour10(in_d[6]), .pHour1(in_d[7]), .pMinute10(in_d[8]),
      .pMinute1(in_d[9]), .pSecond10(in_d[10]), .pSecond1(in_d[11]),
      .Hour10(r_d[gi][0]), .Hour1(r_d[gi][1]), .Minute10(r_d[gi][2]),
      .Minute1(r_d[gi][3]), .Second10(r_d[gi][4]), .Second1(r_d[gi][5]),
      .busy(busy_o[gi]), .complete(complete_o[gi]), .recursive(rec_o[gi]),
      .overflow(ovf_o[gi]), .err(err_o[gi])
    );
  end

  function automatic int hm(input int i);
    return (i == 0) ? 99 : 23;
  endfunction

  function automatic bit sat(input int i);
    return (i != 1);
  endfunction

  // Packed view: six result digits (hour tens first), recursive, overflow, err.
  function automatic logic [26:0] obs(input int i);
    return {r_d[i][0], r_d[i][1], r_d[i][2], r_d[i][3], r_d[i][4], r_d[i][5],
            rec_o[i], ovf_o[i], err_o[i]};
  endfunction

  // Reference model works on whole seconds rather than digit by digit.
  function automatic logic [26:0] model(input int hmax, input bit s, input bit do_sub);
    int a[6];
    int b[6];
    int ha, hb, ma, mb, sa, sb, t, h, m, sec, cs;
    bit e, ov, rc;
    for (int k = 0; k < 6; k++) begin
      a[k] = int'(in_d[k]);
      b[k] = int'(in_d[k + 6]);
    end
    e = (a[1] > 9) || (a[3] > 9) || (a[5] > 9) || (b[1] > 9) || (b[3] > 9) || (b[5] > 9) ||
        (a[2] > 5) || (a[4] > 5) || (b[2] > 5) || (b[4] > 5);
    ha = a[0] * 10 + a[1];
    hb = b[0] * 10 + b[1];
    if (ha > hmax || hb > hmax) e = 1'b1;
    if (e) return {24'd0, 3'b001};
    ma = a[2] * 10 + a[3];  mb = b[2] * 10 + b[3];
    sa = a[4] * 10 + a[5];  sb = b[4] * 10 + b[5];
    ov = 1'b0;
    if (!do_sub) begin
      cs = (sa + sb >= 60) ? 1 : 0;
      rc = (a[5] + b[5] >= 10) || (cs == 1) || (a[3] + b[3] + cs >= 10) || (ma + mb + cs >= 60);
      t = (ha + hb) * 3600 + (ma + mb) * 60 + sa + sb;
      h = t / 3600;  m = (t / 60) % 60;  sec = t % 60;
      if (h > hmax) begin
        ov = 1'b1;
        if (s) begin h = hmax; m = 59; sec = 59; end
        else h = h - hmax - 1;
      end
    end else begin
      cs = (sa < sb) ? 1 : 0;
      rc = (a[5] < b[5]) || (cs == 1) || (a[3] < b[3] + cs) || (ma < mb + cs);
      t = (ha - hb) * 3600 + (ma - mb) * 60 + sa - sb;
      if (t < 0) begin
        ov = 1'b1;
        if (s) t = 0;
        else t = t + (hmax + 1) * 3600;
      end
      h = t / 3600;  m = (t / 60) % 60;  sec = t % 60;
    end
    rc = rc | ov;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10), rc, ov, 1'b0};
  endfunction

  task automatic set_ops(input int ah, input int am, input int as_, input int bh, input int bm, input int bs);
    in_d[0]  = 4'(ah / 10);  in_d[1]  = 4'(ah % 10);
    in_d[2]  = 4'(am / 10);  in_d[3]  = 4'(am % 10);
    in_d[4]  = 4'(as_ / 10); in_d[5]  = 4'(as_ % 10);
    in_d[6]  = 4'(bh / 10);  in_d[7]  = 4'(bh % 10);
    in_d[8]  = 4'(bm / 10);  in_d[9]  = 4'(bm % 10);
    in_d[10] = 4'(bs / 10);  in_d[11] = 4'(bs % 10);
  endtask

  // Pulses en for one capture edge, optionally queues expectations, then scrambles the operands.
  task automatic start_op(input bit do_sub, input bit push);
    @(negedge clock);
    en = 1'b1;
`ifdef TIME_ADDER_SUB_EN
    sub = do_sub;
`endif
    if (push) for (int i = 0; i < N; i++) sb_q.push_back(model(hm(i), sat(i), do_sub));
    @(posedge clock);
    #1;
    en = 1'b0;
    for (int k = 0; k < 12; k++) in_d[k] = 4'($urandom_range(0, 15));
  endtask

  // Sample k counts rising edges since capture; bounded by n.
  task automatic watch(input int n, output int bn, output int cn, output int ck);
    bn = 0; cn = 0; ck = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (busy_o[0] === 1'b1) bn++;
      if (complete_o[0] === 1'b1) begin
        cn++;
        if (ck < 0) ck = k;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({obs(i), busy_o[i], complete_o[i]} !== 29'd0)
        $display("FAIL reset_outputs inst%0d got %h required 0", i, {obs(i), busy_o[i], complete_o[i]});
      else begin passed++; $display("reset inst%0d outputs zero", i); end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int bn, cn, ck;
    logic [26:0] exp, got;
    set_ops(12, 34, 56, 1, 25, 4);
    start_op(1'b0, 1'b1);
    watch(10, bn, cn, ck);
    total++;
    if (bn !== 6) $display("FAIL basic_busy_cycles got %0d required 6", bn); else passed++;
    total++;
    if (ck + 1 !== 6) $display("FAIL basic_complete_edge got %0d required 6", ck + 1); else passed++;
    total++;
    if (cn !== 1) $display("FAIL basic_complete_count got %0d required 1", cn); else passed++;
    total++;
    if (obs(0) !== {24'h140000, 3'b100}) $display("FAIL basic_literal got %h required %h", obs(0), {24'h140000, 3'b100});
    else passed++;
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL basic_result inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("basic inst%0d result %h", i, got); end
    end
  endtask

  task automatic test_overflow;
    int bn, cn, ck;
    logic [26:0] exp, got;
    set_ops(23, 59, 59, 0, 0, 1);
    start_op(1'b0, 1'b1);
    watch(10, bn, cn, ck);
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL overflow_result inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("overflow inst%0d result %h", i, got); end
    end
  endtask

  task automatic test_err;
    int bn, cn, ck;
    logic [26:0] exp, got;
    set_ops(12, 64, 0, 0, 0, 0);
    start_op(1'b0, 1'b1);
    watch(10, bn, cn, ck);
    total++;
    if (cn !== 1) $display("FAIL err_complete_count got %0d required 1", cn); else passed++;
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL err_minute_result inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("err_minute inst%0d result %h", i, got); end
    end
    set_ops(24, 0, 0, 0, 0, 0);
    start_op(1'b0, 1'b1);
    watch(10, bn, cn, ck);
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL err_hour_result inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("err_hour inst%0d result %h", i, got); end
    end
  endtask

  task automatic test_back_to_back;
    int bn, cn, ck, comps;
    logic [26:0] exp, got;
    set_ops(1, 2, 3, 4, 5, 6);
    start_op(1'b0, 1'b1);
    watch(1, bn, cn, ck);
    comps = cn;
    @(negedge clock);
    comps += int'(complete_o[0]);
    set_ops(9, 9, 9, 9, 9, 9);
    en = 1'b1;
    @(posedge clock);
    #1;
    en = 1'b0;
    watch(12, bn, cn, ck);
    comps += cn;
    total++;
    if (comps !== 1) $display("FAIL b2b_complete_count got %0d required 1", comps); else passed++;
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL b2b_result inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("b2b inst%0d result %h", i, got); end
    end
    // Abort a fresh operation while it is in MIN1.
    set_ops(1, 2, 3, 4, 5, 6);
    start_op(1'b0, 1'b0);
    watch(2, bn, cn, ck);
    @(negedge clock);
    total++;
    if (busy_o[0] !== 1'b1) $display("FAIL abort_midop_busy got %b required 1", busy_o[0]); else passed++;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({obs(i), busy_o[i], complete_o[i]} !== 29'd0)
        $display("FAIL abort_outputs inst%0d got %h required 0", i, {obs(i), busy_o[i], complete_o[i]});
      else begin passed++; $display("abort inst%0d outputs zero", i); end
    end
    @(negedge clock);
    reset = 1'b0;
    watch(10, bn, cn, ck);
    total++;
    if (cn !== 0 || bn !== 0) $display("FAIL abort_idle got busy=%0d complete=%0d required 0 0", bn, cn);
    else passed++;
  endtask

  task automatic test_random;
    int bn, cn, ck;
    logic [26:0] exp, got;
    for (int n = 0; n < 5; n++) begin
      set_ops(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
              int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      start_op(1'b0, 1'b1);
      watch(8, bn, cn, ck);
      for (int i = 0; i < N; i++) begin
        exp = sb_q.pop_front();
        got = obs(i);
        total++;
        if (got !== exp) $display("FAIL random%0d inst%0d got %h required %h", n, i, got, exp);
        else begin passed++; $display("random%0d inst%0d result %h", n, i, got); end
      end
    end
  endtask

`ifdef TIME_ADDER_SUB_EN
  task automatic test_sub;
    int bn, cn, ck;
    logic [26:0] exp, got;
    set_ops(10, 0, 0, 0, 0, 1);
    start_op(1'b1, 1'b1);
    watch(8, bn, cn, ck);
    total++;
    if (obs(0) !== {24'h095959, 3'b100}) $display("FAIL sub_literal got %h required %h", obs(0), {24'h095959, 3'b100});
    else passed++;
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL sub_borrow inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("sub_borrow inst%0d result %h", i, got); end
    end
    set_ops(0, 0, 0, 0, 0, 1);
    start_op(1'b1, 1'b1);
    watch(8, bn, cn, ck);
    for (int i = 0; i < N; i++) begin
      exp = sb_q.pop_front();
      got = obs(i);
      total++;
      if (got !== exp) $display("FAIL sub_underflow inst%0d got %h required %h", i, got, exp);
      else begin passed++; $display("sub_underflow inst%0d result %h", i, got); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 12; k++) in_d[k] = 4'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_err();
    test_back_to_back();
    test_random();
`ifdef TIME_ADDER_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
